fifo_rd_stream_adapter: RTL and testbench

//  Read-domain consumer of the async FIFO. Turns the FIFO's rd_en/empty/registered data_out

---
 rtl/fifo_pkg.sv | 19 +
 rtl/stream_skid_buf.sv | 78 +++++++
 rtl/fifo_rd_stream_adapter.sv | 89 ++++++++
 tb/tb_fifo_rd_stream_adapter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the async FIFO and its read-side consumers.
//   DATA_WIDTH_DEF : default data width of the FIFO payload
//   ADDR_WIDTH_DEF : default FIFO address width
//   clog2()        : ceil(log2(value)), elaboration-time helper for pointer/count widths
package fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// DEPTH x DATA_WIDTH register buffer with circular read/write pointers.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push         : write push_data at the tail this edge
//   push_data    : word to store
//   pop          : drop the head word this edge
//   head_data    : word at the head (valid when count != 0)
//   count        : number of stored words, 0..DEPTH
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int unsigned PW        = clog2(DEPTH),
  localparam int unsigned CW        = clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CW-1:0]         count
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  // Explicit wrap compare so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + PW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !pop && count_q == CW'(DEPTH)));
      assert (!(pop && count_q == '0));
    end
  end

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Read-domain consumer of the async FIFO: converts the rd_en/empty interface with a
// registered data_out (1-cycle read latency) into a valid/ready stream, prefetching
// into a small skid buffer to sustain one word per cycle under backpressure.
//   rd_clk, rd_rst_n : read clock, asynchronous active-low reset
//   fifo_empty       : FIFO empty flag
//   fifo_rd_data     : FIFO data_out, valid the cycle after an accepted read
//   fifo_rd_en       : FIFO read request (combinational)
//   drain_en         : allow issuing new reads
//   m_valid/m_ready/m_data : output stream
//   word_cnt         : words handed off, wrapping
//   busy             : buffer non-empty or read outstanding
module fifo_rd_stream_adapter
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned BUF_DEPTH  = 2,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  input  logic                  drain_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  busy
);

  localparam int unsigned CW = clog2(BUF_DEPTH + 1);

  logic [CW-1:0]        count;
  logic [CW:0]          occupancy;
  logic                 room;
  logic                 pop;
  logic                 issue;
  logic                 inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;

  // Buffered plus outstanding words must never exceed the buffer size; a pop this
  // cycle frees a slot, so a read may be issued even when currently at the cap.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign room      = occupancy < (CW + 1)'(BUF_DEPTH);

  assign m_valid    = (count != '0);
  assign pop        = m_valid & m_ready;
  // Gated by reset so no read is requested while the FIFO read side is held in reset.
  assign fifo_rd_en = rd_rst_n & drain_en & ~fifo_empty & (room | pop);
  assign issue      = fifo_rd_en & ~fifo_empty;
  assign busy       = m_valid | inflight_q;
  assign word_cnt   = word_cnt_q;

  always_comb begin
    inflight_d = issue;
    word_cnt_d = word_cnt_q;
    if (pop) word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      inflight_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // The word read last cycle is on fifo_rd_data now; capture it.
  stream_skid_buf #(
    .DEPTH      (BUF_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_buf (
    .clk       (rd_clk),
    .rst_n     (rd_rst_n),
    .push      (inflight_q),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .head_data (m_data),
    .count     (count)
  );

  always @(posedge rd_clk) begin
    if (rd_rst_n) assert (occupancy <= (CW + 1)'(BUF_DEPTH));
  end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
module tb_fifo_rd_stream_adapter;

  logic        rd_clk = 1'b0;
  logic        rd_rst_n = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd_en;
  logic        drain_en = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;
  logic [31:0] word_cnt;
  logic        busy;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream_adapter #(
    .DATA_WIDTH (8),
    .BUF_DEPTH  (2),
    .CNT_WIDTH  (32)
  ) dut (
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .drain_en     (drain_en),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .word_cnt     (word_cnt),
    .busy         (busy)
  );

  // FIFO read-side model: registered data_out, reset together with the adapter.
  logic [7:0] mem [64];
  int         rd_idx;
  int         wr_idx = 0;
  logic       gap_empty = 1'b0;

  assign fifo_empty = gap_empty | (rd_idx >= wr_idx);

  always @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_idx       <= 0;
      fifo_rd_data <= '0;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= mem[rd_idx];
      rd_idx       <= rd_idx + 1;
    end
  end

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q [$];

  int   cyc, rd_cnt, val_cnt, pop_cnt;
  int   first_rd, last_rd, first_val, last_val, first_pop, last_pop;
  logic [7:0] first_data;
  logic       prev_hold;
  logic [7:0] prev_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; rd_cnt = 0; val_cnt = 0; pop_cnt = 0;
    first_rd = -1; last_rd = -1; first_val = -1; last_val = -1;
    first_pop = -1; last_pop = -1; first_data = '0; prev_hold = 1'b0;
  endtask

  task automatic load(input logic [7:0] b);
    mem[wr_idx] = b;
    wr_idx++;
    exp_q.push_back(b);
  endtask

  // Mid-cycle observation: protocol rules, scoreboard pop, per-cycle stats.
  task automatic monitor();
    if (rd_rst_n) begin
      if (fifo_empty) check("rd_en_while_empty", {31'd0, fifo_rd_en}, 32'd0);
      if (prev_hold && m_valid) check("m_data_hold", {24'd0, m_data}, {24'd0, prev_data});
      if (fifo_rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
      if (m_valid) begin
        if (first_val < 0) begin
          first_val  = cyc;
          first_data = m_data;
        end
        val_cnt++;
        last_val = cyc;
      end
      if (m_valid && m_ready) begin
        pop_cnt++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        if (exp_q.size() == 0) check("spurious_pop", {24'd0, m_data}, 32'hFFFF_FFFF);
        else                   check("m_data_order", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
      end
      prev_hold = m_valid & ~m_ready;
      prev_data = m_data;
    end else begin
      prev_hold = 1'b0;
    end
    cyc++;
  endtask

  // One clock: sample at the falling edge, return 1 time unit after the rising edge.
  task automatic step();
    @(negedge rd_clk);
    monitor();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic do_reset();
    rd_rst_n  = 1'b0;
    drain_en  = 1'b0;
    m_ready   = 1'b0;
    gap_empty = 1'b0;
    wr_idx    = 0;
    exp_q.delete();
    repeat (2) @(posedge rd_clk);
    #1;
    rd_rst_n = 1'b1;
    clear_stats();
  endtask

  initial begin
    clear_stats();

    // 1: asynchronous reset mid-cycle
    do_reset();
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_word_cnt", word_cnt, 32'd0);
    load(8'h5A); load(8'h5B);
    drain_en = 1'b1;
    repeat (4) step();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("t1_word_cnt_pre", word_cnt, 32'd1);
    #3;
    rd_rst_n = 1'b0;
    exp_q.delete();
    wr_idx = 0;
    #1;
    check("t1_m_valid", {31'd0, m_valid}, 32'd0);
    check("t1_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("t1_word_cnt", word_cnt, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_m_data", {24'd0, m_data}, 32'd0);

    // 2: streaming
    do_reset();
    load(8'h11); load(8'h22); load(8'h33);
    m_ready = 1'b1; drain_en = 1'b1;
    repeat (10) step();
    check("t2_rd_cnt", rd_cnt, 3);
    check("t2_rd_span", last_rd - first_rd, 2);
    check("t2_latency", first_val - first_rd, 2);
    check("t2_val_cnt", val_cnt, 3);
    check("t2_val_span", last_val - first_val, 2);
    check("t2_word_cnt", word_cnt, 32'd3);
    check("t2_left", exp_q.size(), 0);
    check("t2_busy", {31'd0, busy}, 32'd0);

    // 3: backpressure
    do_reset();
    for (int i = 1; i <= 5; i++) load(8'(i * 8'h11));
    drain_en = 1'b1;
    repeat (8) step();
    check("t3_rd_cnt", rd_cnt, 2);
    check("t3_rd_en_off", {31'd0, fifo_rd_en}, 32'd0);
    check("t3_m_valid", {31'd0, m_valid}, 32'd1);
    check("t3_m_data_head", {24'd0, m_data}, 32'h11);
    clear_stats();
    m_ready = 1'b1;
    repeat (10) step();
    check("t3_pop_cnt", pop_cnt, 5);
    check("t3_pop_span", last_pop - first_pop, 4);
    check("t3_word_cnt", word_cnt, 32'd5);

    // 4: FIFO empty toggling every other cycle
    do_reset();
    for (int i = 1; i <= 4; i++) load(8'h40 + 8'(i));
    m_ready = 1'b1; drain_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      gap_empty = (i % 2 == 0);
      step();
    end
    gap_empty = 1'b0;
    repeat (3) step();
    check("t4_pop_cnt", pop_cnt, 4);
    check("t4_left", exp_q.size(), 0);
    check("t4_word_cnt", word_cnt, 32'd4);
    check("t4_valid_gaps", {31'd0, val_cnt < (last_val - first_val + 1)}, 32'd1);

    // 5: drain_en dropped with one word buffered and one in flight
    do_reset();
    load(8'h51); load(8'h52); load(8'h53);
    drain_en = 1'b1;
    step();
    step();
    drain_en = 1'b0;
    check("t5_busy_on", {31'd0, busy}, 32'd1);
    check("t5_m_valid", {31'd0, m_valid}, 32'd1);
    check("t5_rd_en_off", {31'd0, fifo_rd_en}, 32'd0);
    clear_stats();
    repeat (3) step();
    check("t5_no_reads", rd_cnt, 0);
    m_ready = 1'b1;
    repeat (4) step();
    check("t5_pop_cnt", pop_cnt, 2);
    check("t5_word_cnt", word_cnt, 32'd2);
    check("t5_busy_off", {31'd0, busy}, 32'd0);
    check("t5_fifo_left", exp_q.size(), 1);

    // 6: reset mid-operation (deepest state reachable at depth 2: count=1, inflight=1)
    do_reset();
    load(8'h61); load(8'h62); load(8'h63);
    drain_en = 1'b1;
    step();
    step();
    check("t6_busy_pre", {31'd0, busy}, 32'd1);
    #2;
    rd_rst_n = 1'b0;
    exp_q.delete();
    wr_idx = 0;
    #1;
    check("t6_m_valid", {31'd0, m_valid}, 32'd0);
    check("t6_word_cnt", word_cnt, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    @(posedge rd_clk);
    #1;
    rd_rst_n = 1'b1;
    load(8'hA0); load(8'hA1); load(8'hA2);
    m_ready = 1'b1;
    clear_stats();
    repeat (10) step();
    check("t6_first_data", {24'd0, first_data}, 32'hA0);
    check("t6_pop_cnt", pop_cnt, 3);
    check("t6_word_cnt", word_cnt, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
